// File: rtl/regif_pkg.sv
// Shared types and constants for the register-interface master arbiter:
// FSM states, debug view and IPIF bus widths.
package regif_pkg;

  localparam int IPIF_AW          = 32;
  localparam int IPIF_DW          = 32;
  localparam int IPIF_BEW         = 4;
  localparam int DEF_TIMEOUT_CYC  = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } state_t;

  // Debug view: FSM state plus the data-beat handshakes seen in the current transaction.
  typedef struct packed {
    state_t state;
    logic   wr_beat_taken;
    logic   rd_beat_seen;
  } dbg_t;

endpackage

// File: rtl/regif_mst_arbiter_if.sv
// IPIF single-beat master bus between the arbiter (master) and the bus
// attachment (slave).
interface regif_mst_arbiter_if;
  import regif_pkg::*;

  logic                IP2Bus_MstRd_Req;
  logic                IP2Bus_MstWr_Req;
  logic [IPIF_AW-1:0]  IP2Bus_Mst_Addr;
  logic [IPIF_BEW-1:0] IP2Bus_Mst_BE;
  logic                IP2Bus_Mst_Lock;
  logic                IP2Bus_Mst_Reset;
  logic [IPIF_DW-1:0]  IP2Bus_MstWr_d;
  logic                Bus2IP_Mst_CmdAck;
  logic                Bus2IP_Mst_Cmplt;
  logic                Bus2IP_Mst_Error;
  logic                Bus2IP_Mst_Timeout;
  logic [IPIF_DW-1:0]  Bus2IP_MstRd_d;
  logic                Bus2IP_MstRd_src_rdy_n;
  logic                Bus2IP_MstWr_dst_rdy_n;

  modport master (
    output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
           IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Timeout,
           Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
  );

  modport slave (
    input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
           IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_Mst_Timeout,
           Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping
// modulo N. Returns one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] lo_idx;
  logic [IW-1:0] hi_idx;
  logic          lo_ok;
  logic          hi_ok;

  // Descending scan leaves the lowest matching index in each candidate.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    lo_ok  = 1'b0;
    hi_ok  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        lo_ok  = 1'b1;
        if (i >= int'(ptr)) begin
          hi_idx = IW'(i);
          hi_ok  = 1'b1;
        end
      end
    end
    idx = hi_ok ? hi_idx : lo_idx;
    any = lo_ok;
    gnt = lo_ok ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/regif_mst_arbiter.sv
// Round-robin sequencer sharing the single-beat IPIF master bus between
// NUM_REQ requesters, one transaction at a time, with a watchdog abort.
module regif_mst_arbiter import regif_pkg::*; #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TO_W        = 10
) (
  input  logic                     reg_int_clk,
  input  logic                     reg_int_reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ*32-1:0]    req_addr,
  input  logic [NUM_REQ*4-1:0]     req_be,
  input  logic [NUM_REQ*32-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]       req_done,
  output logic                     req_err,
  output logic [31:0]              req_rdata,
  regif_mst_arbiter_if.master      bus,
  output dbg_t                     dbg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester handshake: req_valid[i] is raised with stable wr/addr/be/wdata and
  // held until req_done[i] pulses for one cycle; req_err/req_rdata qualify that pulse.

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, gnt_q;
  logic [NUM_REQ-1:0]   gnt_oh_q;
  logic                 op_wr_q;
  logic [IPIF_AW-1:0]   addr_q;
  logic [IPIF_BEW-1:0]  be_q;
  logic [IPIF_DW-1:0]   wdata_q;
  logic [TO_W-1:0]      cnt_q;
  logic                 err_q;
  logic [IPIF_DW-1:0]   cap_q, cap_next, rdata_q;
  logic                 rd_seen_q, wr_taken_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 busy, wd_hit, rd_beat, wr_beat;
  logic                 fin, fin_err, fin_abort;

  logic [31:0] addr_arr  [NUM_REQ];
  logic [3:0]  be_arr    [NUM_REQ];
  logic [31:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[32*g +: 32];
    assign be_arr[g]    = req_be[4*g +: 4];
    assign wdata_arr[g] = req_wdata[32*g +: 32];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign busy     = (state_q == CMD) || (state_q == XFER);
  assign wd_hit   = busy && (cnt_q == TO_W'(TIMEOUT_CYC));
  assign rd_beat  = busy && !op_wr_q && !bus.Bus2IP_MstRd_src_rdy_n;
  assign wr_beat  = busy && op_wr_q && !bus.Bus2IP_MstWr_dst_rdy_n;
  assign cap_next = rd_beat ? bus.Bus2IP_MstRd_d : cap_q;

  // Priority on exit: watchdog abort, then bus timeout, then normal completion.
  always_comb begin
    state_d   = state_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_abort = 1'b0;
    case (state_q)
      IDLE: if (arb_any) state_d = CMD;
      CMD: begin
        if (wd_hit) begin
          state_d = RESP; fin = 1'b1; fin_err = 1'b1; fin_abort = 1'b1;
        end else if (bus.Bus2IP_Mst_Timeout) begin
          state_d = RESP; fin = 1'b1; fin_err = 1'b1;
        end else if (bus.Bus2IP_Mst_CmdAck) begin
          if (bus.Bus2IP_Mst_Cmplt) begin
            state_d = RESP; fin = 1'b1; fin_err = bus.Bus2IP_Mst_Error;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (wd_hit) begin
          state_d = RESP; fin = 1'b1; fin_err = 1'b1; fin_abort = 1'b1;
        end else if (bus.Bus2IP_Mst_Timeout) begin
          state_d = RESP; fin = 1'b1; fin_err = 1'b1;
        end else if (bus.Bus2IP_Mst_Cmplt) begin
          state_d = RESP; fin = 1'b1; fin_err = bus.Bus2IP_Mst_Error;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge reg_int_clk or negedge reg_int_reset_n) begin
    if (!reg_int_reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      gnt_oh_q   <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      cap_q      <= '0;
      rdata_q    <= '0;
      rd_seen_q  <= 1'b0;
      wr_taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && arb_any) begin
        gnt_q      <= arb_idx;
        gnt_oh_q   <= arb_gnt;
        op_wr_q    <= req_wr[arb_idx];
        addr_q     <= addr_arr[arb_idx];
        be_q       <= be_arr[arb_idx];
        wdata_q    <= wdata_arr[arb_idx];
        cnt_q      <= '0;
        cap_q      <= '0;
        rd_seen_q  <= 1'b0;
        wr_taken_q <= 1'b0;
      end
      if (busy) begin
        cnt_q <= cnt_q + TO_W'(1);
        cap_q <= cap_next;
        if (rd_beat) rd_seen_q  <= 1'b1;
        if (wr_beat) wr_taken_q <= 1'b1;
      end
      if (fin) begin
        err_q   <= fin_err;
        rdata_q <= fin_abort ? '0 : cap_next;
      end
      if (state_q == RESP) begin
        ptr_q <= (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + IW'(1);
      end
    end
  end

  // Commands drop in the watchdog cycle so the bus sees Reset with no request.
  assign bus.IP2Bus_MstRd_Req = (state_q == CMD) && !op_wr_q && !wd_hit;
  assign bus.IP2Bus_MstWr_Req = (state_q == CMD) && op_wr_q && !wd_hit;
  assign bus.IP2Bus_Mst_Addr  = addr_q;
  assign bus.IP2Bus_Mst_BE    = be_q;
  assign bus.IP2Bus_Mst_Lock  = 1'b0;
  assign bus.IP2Bus_Mst_Reset = wd_hit;
  assign bus.IP2Bus_MstWr_d   = wdata_q;

  assign req_done  = (state_q == RESP) ? gnt_oh_q : '0;
  assign req_err   = (state_q == RESP) && err_q;
  assign req_rdata = rdata_q;
  assign dbg       = {state_q, wr_taken_q, rd_seen_q};

endmodule

// File: tb/tb_regif_mst_arbiter.sv
// Bench for regif_mst_arbiter: vector table of single transactions against a
// scripted bus responder, then async-reset and round-robin sequences.
module tb_regif_mst_arbiter;
  import regif_pkg::*;

  localparam int NR = 2;
  localparam int TO = 15;
  localparam int W  = NR + 33;

  logic reg_int_clk = 1'b0;
  logic reg_int_reset_n;
  always #5 reg_int_clk = ~reg_int_clk;

  logic [NR-1:0]    req_valid, req_wr, req_done;
  logic [NR*32-1:0] req_addr, req_wdata;
  logic [NR*4-1:0]  req_be;
  logic             req_err;
  logic [31:0]      req_rdata;
  dbg_t             dbg;

  regif_mst_arbiter_if bus();

  regif_mst_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO), .TO_W(10)) dut (
    .reg_int_clk     (reg_int_clk),
    .reg_int_reset_n (reg_int_reset_n),
    .req_valid       (req_valid),
    .req_wr          (req_wr),
    .req_addr        (req_addr),
    .req_be          (req_be),
    .req_wdata       (req_wdata),
    .req_done        (req_done),
    .req_err         (req_err),
    .req_rdata       (req_rdata),
    .bus             (bus),
    .dbg             (dbg)
  );

  typedef struct {
    int          r;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ack_at;
    int          cmplt_at;
    int          rd_at;
    int          to_at;
    bit          bus_err;
    logic [31:0] rd;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_done_at;
    int          exp_req_cyc;
    int          exp_mrst;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(int r, bit wr, logic [31:0] addr, logic [3:0] be,
                              logic [31:0] wdata, int ack_at, int cmplt_at, int rd_at,
                              int to_at, bit bus_err, logic [31:0] rd, bit exp_err,
                              logic [31:0] exp_rdata, int done_at, int req_cyc, int mrst);
    vec_t v;
    v.r = r; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
    v.ack_at = ack_at; v.cmplt_at = cmplt_at; v.rd_at = rd_at; v.to_at = to_at;
    v.bus_err = bus_err; v.rd = rd; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    v.exp_done_at = done_at; v.exp_req_cyc = req_cyc; v.exp_mrst = mrst;
    return v;
  endfunction

  task automatic bus_idle();
    bus.Bus2IP_Mst_CmdAck      = 1'b0;
    bus.Bus2IP_Mst_Cmplt       = 1'b0;
    bus.Bus2IP_Mst_Error       = 1'b0;
    bus.Bus2IP_Mst_Timeout     = 1'b0;
    bus.Bus2IP_MstRd_d         = 32'hFFFF_FFFF;
    bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
    bus.Bus2IP_MstWr_dst_rdy_n = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_done"},  req_done, '0);
    check({tag, "_err"},   req_err, 1'b0);
    check({tag, "_rdata"}, req_rdata, 32'h0);
    check({tag, "_bus"}, {bus.IP2Bus_MstRd_Req, bus.IP2Bus_MstWr_Req, bus.IP2Bus_Mst_Addr,
                          bus.IP2Bus_Mst_BE, bus.IP2Bus_Mst_Lock, bus.IP2Bus_Mst_Reset,
                          bus.IP2Bus_MstWr_d}, '0);
    check({tag, "_state"}, dbg.state, IDLE);
  endtask

  // Called at a negedge; cycle 0 is the first negedge with a command request high.
  task automatic do_txn(input vec_t v, input bit drive_req);
    int c, reqc, mrst;
    bit seen, got, bad_addr, bad_op, both, bad_wd;
    logic [NR-1:0] oh;
    logic [W-1:0]  w;
    c = 0; reqc = 0; mrst = 0;
    seen = 0; got = 0; bad_addr = 0; bad_op = 0; both = 0; bad_wd = 0;
    if (drive_req) begin
      req_valid[v.r]          = 1'b1;
      req_wr[v.r]             = v.wr;
      req_addr[v.r*32 +: 32]  = v.addr;
      req_be[v.r*4 +: 4]      = v.be;
      req_wdata[v.r*32 +: 32] = v.wdata;
    end
    oh = NR'(1) << v.r;
    exp_q.push_back({oh, v.exp_err, v.exp_rdata});
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge reg_int_clk);
      seen = bus.IP2Bus_MstRd_Req | bus.IP2Bus_MstWr_Req;
    end
    check("req_seen", seen, 1'b1);
    while (seen && !got && c < 100) begin
      if (req_done != '0) begin
        got = 1;
      end else begin
        if (bus.IP2Bus_MstRd_Req | bus.IP2Bus_MstWr_Req) begin
          reqc++;
          if (bus.IP2Bus_Mst_Addr !== v.addr || bus.IP2Bus_Mst_BE !== v.be) bad_addr = 1;
          if (v.wr ? bus.IP2Bus_MstRd_Req : bus.IP2Bus_MstWr_Req) bad_op = 1;
        end
        if (bus.IP2Bus_MstRd_Req & bus.IP2Bus_MstWr_Req) both = 1;
        if (bus.IP2Bus_Mst_Reset) mrst++;
        if (v.wr && bus.IP2Bus_MstWr_d !== v.wdata) bad_wd = 1;
        bus_idle();
        if (c == v.ack_at) bus.Bus2IP_Mst_CmdAck = 1'b1;
        if (c == v.cmplt_at) begin
          bus.Bus2IP_Mst_Cmplt = 1'b1;
          bus.Bus2IP_Mst_Error = v.bus_err;
          if (v.wr) bus.Bus2IP_MstWr_dst_rdy_n = 1'b0;
        end
        if (!v.wr && c == ((v.rd_at >= 0) ? v.rd_at : v.cmplt_at)) begin
          bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
          bus.Bus2IP_MstRd_d         = v.rd;
        end
        if (c == v.to_at) bus.Bus2IP_Mst_Timeout = 1'b1;
        @(negedge reg_int_clk);
        c++;
      end
    end
    check("done_seen", got, 1'b1);
    w = exp_q.pop_front();
    check("done_word", {req_done, req_err, req_rdata}, w);
    check("done_cycle", c, v.exp_done_at);
    check("req_cycles", reqc, v.exp_req_cyc);
    check("mst_reset", mrst, v.exp_mrst);
    check("cmd_fields", {bad_addr, bad_op, both, bad_wd}, 4'b0);
    bus_idle();
    if (drive_req) req_valid[v.r] = 1'b0;
    @(negedge reg_int_clk);
    check("done_width", req_done, '0);
  endtask

  vec_t vecs[9];
  vec_t v;
  logic [31:0] rnd;
  bit seen;

  initial begin
    rnd = 32'($urandom_range(32'h7FFF_FFFF, 32'h1000_0000));
    //            r  wr addr          be     wdata         ack cmp rdat to  berr rd             xerr xrdata        done reqc mrst
    vecs[0] = mk(0, 0, 32'h0000_0040, 4'hF, 32'h0,        2,  4,  -1,  -1, 0,   32'hDEAD_BEEF, 0,   32'hDEAD_BEEF, 5,   3,   0);
    vecs[1] = mk(1, 1, 32'h0000_0010, 4'hF, 32'h1234_5678, 3, 3,  -1,  -1, 0,   32'h0,         0,   32'h0,         4,   4,   0);
    vecs[2] = mk(0, 0, 32'h0000_0020, 4'hF, 32'h0,        1,  2,  -1,  -1, 1,   32'hCAFE_0001, 1,   32'hCAFE_0001, 3,   2,   0);
    vecs[3] = mk(1, 0, 32'h0000_0080, 4'hF, 32'h0,        -1, -1, -1,  -1, 0,   32'h1111_2222, 1,   32'h0,         16,  15,  1);
    vecs[4] = mk(0, 0, 32'h0000_0084, 4'hF, 32'h0,        0,  1,  -1,  -1, 0,   rnd,           0,   rnd,           2,   1,   0);
    vecs[5] = mk(1, 0, 32'h0000_0088, 4'hF, 32'h0,        1,  -1, -1,  3,  0,   32'h0,         1,   32'h0,         4,   2,   0);
    vecs[6] = mk(0, 0, 32'h0000_008C, 4'hF, 32'h0,        -1, -1, -1,  2,  0,   32'h0,         1,   32'h0,         3,   3,   0);
    vecs[7] = mk(1, 1, 32'h0000_002C, 4'h3, 32'hA5A5_5A5A, 0, 2,  -1,  -1, 0,   32'h0,         0,   32'h0,         3,   1,   0);
    vecs[8] = mk(0, 0, 32'h0000_0044, 4'hC, 32'h0,        1,  3,  2,   -1, 0,   32'h5A5A_0F0F, 0,   32'h5A5A_0F0F, 4,   2,   0);

    reg_int_reset_n = 1'b0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    bus_idle();
    repeat (2) @(negedge reg_int_clk);
    check_quiet("reset");
    reg_int_reset_n = 1'b1;
    @(negedge reg_int_clk);

    for (int i = 0; i < 9; i++) do_txn(vecs[i], 1'b1);

    // Async reset while a read sits in XFER.
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[63:32] = 32'h0000_0300; req_be[7:4] = 4'hF;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge reg_int_clk);
      seen = bus.IP2Bus_MstRd_Req;
    end
    check("rst_req_seen", seen, 1'b1);
    bus.Bus2IP_Mst_CmdAck = 1'b1;
    @(negedge reg_int_clk);
    bus_idle();
    check("rst_in_xfer", dbg.state, XFER);
    #2 reg_int_reset_n = 1'b0;
    #1 check_quiet("async_rst");
    req_valid = '0;
    @(negedge reg_int_clk);
    reg_int_reset_n = 1'b1;
    @(negedge reg_int_clk);

    // Both requesters held valid: grants must alternate starting from requester 0.
    req_valid = 2'b11; req_wr = 2'b00; req_be = 8'hFF;
    req_addr = {32'h0000_0200, 32'h0000_0100};
    for (int k = 0; k < 6; k++) begin
      rnd = 32'($urandom_range(32'hFFFF_FFFE, 0));
      v = mk(k % 2, 0, (k % 2) ? 32'h0000_0200 : 32'h0000_0100, 4'hF, 32'h0,
             0, 0, -1, -1, 0, rnd, 0, rnd, 1, 1, 0);
      do_txn(v, 1'b0);
    end
    req_valid = '0;
    repeat (3) @(negedge reg_int_clk);
    check("end_idle", dbg.state, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
